// File: rtl/sobel_window_sequencer.sv
// Address and control sequencer for the Sobel 3x3 window traversal: fetches window pixels,
// triggers the gradient calculation and writes one result pixel per window position.
module sobel_window_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 10
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              load_pixel,
    output logic [3:0]        pix_index,
    output logic              shift_lr,
    output logic              calc_start,
    input  logic              calc_done,
    output logic              busy,
    output logic              image_done
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SKIP      = 4'd1,
        S_LOAD9     = 4'd2,
        S_LOAD3     = 4'd3,
        S_CALC      = 4'd4,
        S_WAIT_CALC = 4'd5,
        S_WRITE     = 4'd6,
        S_ADVANCE   = 4'd7,
        S_SHIFT     = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    state_t              state_r, state_s;
    logic [DIM_W-1:0]    width_r, width_s;
    logic [DIM_W-1:0]    height_r, height_s;
    logic [DIM_W-1:0]    col_r, col_s;
    logic [DIM_W-1:0]    row_r, row_s;
    logic [3:0]          slot_r, slot_s;
    logic [ADDR_W-1:0]   row_base_r, row_base_s;
    logic [ADDR_W-1:0]   win_base_r, win_base_s;
    logic [ADDR_W-1:0]   dst_addr_r, dst_addr_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic                mem_req_r, mem_we_r, shift_r, calc_start_r, busy_r, done_r;
    logic                ack_s;
    logic [ADDR_W-1:0]   width_ext_s;

    assign ack_s       = mem_req_r & mem_ack;
    assign width_ext_s = ADDR_W'(width_r);

    // Next-state and counter logic; addresses advance incrementally so no multiplier is needed.
    always_comb begin
        state_s    = state_r;
        width_s    = width_r;
        height_s   = height_r;
        col_s      = col_r;
        row_s      = row_r;
        slot_s     = slot_r;
        row_base_s = row_base_r;
        win_base_s = win_base_r;
        dst_addr_s = dst_addr_r;
        mem_addr_s = mem_addr_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    width_s    = img_width;
                    height_s   = img_height;
                    col_s      = '0;
                    row_s      = '0;
                    slot_s     = 4'd0;
                    row_base_s = src_base;
                    win_base_s = src_base;
                    dst_addr_s = dst_base;
                    mem_addr_s = src_base;
                    // Images too small for a single window take a one-cycle detour with no memory access
                    if ((img_width < DIM_W'(3)) || (img_height < DIM_W'(3))) begin
                        state_s = S_SKIP;
                    end else begin
                        state_s = S_LOAD9;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SKIP: state_s = S_DONE;
            S_LOAD9: begin
                if (ack_s) begin
                    if (slot_r == 4'd8) begin
                        state_s = S_CALC;
                    end else begin
                        slot_s = slot_r + 4'd1;
                        if ((slot_r == 4'd2) || (slot_r == 4'd5)) begin
                            mem_addr_s = mem_addr_r + width_ext_s - ADDR_W'(2);
                        end else begin
                            mem_addr_s = mem_addr_r + ADDR_W'(1);
                        end
                    end
                end else begin
                    state_s = S_LOAD9;
                end
            end
            S_LOAD3: begin
                if (ack_s) begin
                    if (slot_r == 4'd8) begin
                        state_s = S_CALC;
                    end else begin
                        slot_s     = slot_r + 4'd3;
                        mem_addr_s = mem_addr_r + width_ext_s;
                    end
                end else begin
                    state_s = S_LOAD3;
                end
            end
            S_CALC: state_s = S_WAIT_CALC;
            S_WAIT_CALC: begin
                if (calc_done) begin
                    state_s    = S_WRITE;
                    mem_addr_s = dst_addr_r;
                end else begin
                    state_s = S_WAIT_CALC;
                end
            end
            S_WRITE: begin
                if (ack_s) begin
                    state_s    = S_ADVANCE;
                    dst_addr_s = dst_addr_r + ADDR_W'(1);
                end else begin
                    state_s = S_WRITE;
                end
            end
            S_ADVANCE: begin
                if (col_r < (width_r - DIM_W'(3))) begin
                    col_s      = col_r + DIM_W'(1);
                    win_base_s = win_base_r + ADDR_W'(1);
                    state_s    = S_SHIFT;
                end else if (row_r < (height_r - DIM_W'(3))) begin
                    col_s      = '0;
                    row_s      = row_r + DIM_W'(1);
                    row_base_s = row_base_r + width_ext_s;
                    win_base_s = row_base_r + width_ext_s;
                    mem_addr_s = row_base_r + width_ext_s;
                    slot_s     = 4'd0;
                    state_s    = S_LOAD9;
                end else begin
                    state_s = S_DONE;
                end
            end
            S_SHIFT: begin
                slot_s     = 4'd2;
                mem_addr_s = win_base_r + ADDR_W'(2);
                state_s    = S_LOAD3;
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, counters and output registers; outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r      <= S_IDLE;
            width_r      <= '0;
            height_r     <= '0;
            col_r        <= '0;
            row_r        <= '0;
            slot_r       <= 4'd0;
            row_base_r   <= '0;
            win_base_r   <= '0;
            dst_addr_r   <= '0;
            mem_addr_r   <= '0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            shift_r      <= 1'b0;
            calc_start_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            width_r      <= width_s;
            height_r     <= height_s;
            col_r        <= col_s;
            row_r        <= row_s;
            slot_r       <= slot_s;
            row_base_r   <= row_base_s;
            win_base_r   <= win_base_s;
            dst_addr_r   <= dst_addr_s;
            mem_addr_r   <= mem_addr_s;
            mem_req_r    <= (state_s == S_LOAD9) || (state_s == S_LOAD3) || (state_s == S_WRITE);
            mem_we_r     <= (state_s == S_WRITE);
            shift_r      <= (state_s == S_SHIFT);
            calc_start_r <= (state_s == S_CALC);
            busy_r       <= (state_s != S_IDLE);
            done_r       <= (state_s == S_DONE);
        end
    end

    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign pix_index  = slot_r;
    assign shift_lr   = shift_r;
    assign calc_start = calc_start_r;
    assign busy       = busy_r;
    assign image_done = done_r;
    assign load_pixel = ack_s & ~mem_we_r & ((state_r == S_LOAD9) || (state_r == S_LOAD3));

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Directed bench for sobel_window_sequencer: records the read/write/shift stream of each image
// and compares it with hand-derived window traversals.
module tb_sobel_window_sequencer;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic [9:0]  img_width;
    logic [9:0]  img_height;
    logic [15:0] src_base;
    logic [15:0] dst_base;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic        load_pixel;
    logic [3:0]  pix_index;
    logic        shift_lr;
    logic        calc_start;
    logic        calc_done;
    logic        busy;
    logic        image_done;

    int checks   = 0;
    int failures = 0;
    int shifts_seen;
    int dones;
    logic [31:0] events[$];
    logic [31:0] expq[$];

    localparam logic [31:0] EV_SH = 32'h0030_0000;

    sobel_window_sequencer #(.ADDR_W(16), .DIM_W(10)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .img_width(img_width), .img_height(img_height),
        .src_base(src_base), .dst_base(dst_base),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .load_pixel(load_pixel), .pix_index(pix_index), .shift_lr(shift_lr),
        .calc_start(calc_start), .calc_done(calc_done),
        .busy(busy), .image_done(image_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ev_rd(input logic [15:0] a, input logic [3:0] s);
        return {8'h00, 4'h1, s, a};
    endfunction

    function automatic logic [31:0] ev_wr(input logic [15:0] a);
        return {8'h00, 4'h2, 4'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full 3x3 window with top-left source pixel (c,r): address = base + y*W + x
    task automatic exp_win(input logic [15:0] sb, input int w, input int c, input int r);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                expq.push_back(ev_rd(sb + 16'((r + y) * w + c + x), 4'(y * 3 + x)));
    endtask

    task automatic exp_col(input logic [15:0] sb, input int w, input int c, input int r);
        for (int y = 0; y < 3; y++)
            expq.push_back(ev_rd(sb + 16'((r + y) * w + c + 2), 4'(y * 3 + 2)));
    endtask

    task automatic compare_events(input string tag);
        chk({tag, "_len"}, 32'(events.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < events.size(); i++)
            chk($sformatf("%s_ev%0d", tag, i), events[i], expq[i]);
    endtask

    task automatic run_image(input string tag, input logic [9:0] w, input logic [9:0] h,
                             input logic [15:0] sb, input logic [15:0] db, input int stall_max,
                             input int spur_cyc, input bit abort_load3);
        int          cyc;
        int          stall;
        logic        prev_cs;
        logic        hold_valid;
        logic [15:0] hold_addr;
        logic        hold_we;
        @(negedge clk);
        img_width = w; img_height = h; src_base = sb; dst_base = db;
        start = 1'b1; mem_ack = 1'b0; calc_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, "_req_after_start"}, 32'(mem_req), 32'd1);
        events.delete();
        shifts_seen = 0; dones = 0; cyc = 0; prev_cs = 1'b0; hold_valid = 1'b0;
        hold_addr = 16'h0000; hold_we = 1'b0;
        stall = int'($urandom_range(0, stall_max));
        while (cyc < 2000) begin
            calc_done = prev_cs;
            if (cyc == spur_cyc) begin
                start = 1'b1; img_width = 10'd7; src_base = 16'h1234;
            end else begin
                start = 1'b0;
            end
            if (abort_load3 && shifts_seen > 0 && mem_req) break;
            if (mem_req) begin
                if (stall > 0) begin mem_ack = 1'b0; stall--; end
                else mem_ack = 1'b1;
            end else begin
                mem_ack = (stall_max > 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #1;
            if (hold_valid && mem_req) begin
                chk({tag, "_stall_addr"}, 32'(mem_addr), 32'(hold_addr));
                chk({tag, "_stall_we"}, 32'(mem_we), 32'(hold_we));
            end
            if (mem_req && mem_ack) begin
                if (mem_we) events.push_back(ev_wr(mem_addr));
                else        events.push_back(ev_rd(mem_addr, pix_index));
                chk({tag, "_load_pixel_ack"}, 32'(load_pixel), mem_we ? 32'd0 : 32'd1);
                stall = int'($urandom_range(0, stall_max));
                hold_valid = 1'b0;
            end else begin
                if (!mem_ack) chk({tag, "_load_pixel_noack"}, 32'(load_pixel), 32'd0);
                hold_valid = mem_req; hold_addr = mem_addr; hold_we = mem_we;
            end
            if (shift_lr) begin events.push_back(EV_SH); shifts_seen++; end
            prev_cs = calc_start;
            if (image_done) begin
                dones++;
                @(negedge clk);
                chk({tag, "_busy_falls"}, 32'(busy), 32'd0);
                chk({tag, "_done_one_cycle"}, 32'(image_done), 32'd0);
                break;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; calc_done = 1'b0;
        if (!abort_load3) chk({tag, "_image_done_count"}, 32'(dones), 32'd1);
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; img_width = 10'd0; img_height = 10'd0;
        src_base = 16'h0000; dst_base = 16'h0000; mem_ack = 1'b0; calc_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_pix_index", 32'(pix_index), 32'd0);
        chk("rst_image_done", 32'(image_done), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // 4x4 image, ack tied high: two rows of two windows
        expq.delete();
        exp_win(16'h0100, 4, 0, 0); expq.push_back(ev_wr(16'h0200)); expq.push_back(EV_SH);
        exp_col(16'h0100, 4, 1, 0); expq.push_back(ev_wr(16'h0201));
        exp_win(16'h0100, 4, 0, 1); expq.push_back(ev_wr(16'h0202)); expq.push_back(EV_SH);
        exp_col(16'h0100, 4, 1, 1); expq.push_back(ev_wr(16'h0203));
        run_image("t1", 10'd4, 10'd4, 16'h0100, 16'h0200, 0, -1, 1'b0);
        compare_events("t1");
        chk("t1_shifts", 32'(shifts_seen), 32'd2);

        // Degenerate 2x5 image: no memory traffic, done two cycles after start
        @(negedge clk);
        img_width = 10'd2; img_height = 10'd5; src_base = 16'h0700; dst_base = 16'h0800;
        start = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t2_busy_c1", 32'(busy), 32'd1);
        chk("t2_done_c1", 32'(image_done), 32'd0);
        chk("t2_req_c1", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("t2_busy_c2", 32'(busy), 32'd1);
        chk("t2_done_c2", 32'(image_done), 32'd1);
        chk("t2_req_c2", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("t2_busy_c3", 32'(busy), 32'd0);
        chk("t2_done_c3", 32'(image_done), 32'd0);

        // 3x3 image: single window, single write
        expq.delete();
        exp_win(16'h0040, 3, 0, 0); expq.push_back(ev_wr(16'h0300));
        run_image("t3", 10'd3, 10'd3, 16'h0040, 16'h0300, 0, -1, 1'b0);
        compare_events("t3");
        chk("t3_shifts", 32'(shifts_seen), 32'd0);

        // Same 4x4 traversal under random ack stalls
        expq.delete();
        exp_win(16'h0100, 4, 0, 0); expq.push_back(ev_wr(16'h0200)); expq.push_back(EV_SH);
        exp_col(16'h0100, 4, 1, 0); expq.push_back(ev_wr(16'h0201));
        exp_win(16'h0100, 4, 0, 1); expq.push_back(ev_wr(16'h0202)); expq.push_back(EV_SH);
        exp_col(16'h0100, 4, 1, 1); expq.push_back(ev_wr(16'h0203));
        run_image("t4", 10'd4, 10'd4, 16'h0100, 16'h0200, 5, -1, 1'b0);
        compare_events("t4");

        // Reset asserted in the first LOAD3 cycle, then a fresh image
        run_image("t5a", 10'd4, 10'd4, 16'h0100, 16'h0200, 0, -1, 1'b1);
        chk("t5_load3_req", 32'(mem_req), 32'd1);
        chk("t5_load3_addr", 32'(mem_addr), 32'h0103);
        chk("t5_load3_slot", 32'(pix_index), 32'd2);
        mem_ack = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        chk("t5_rst_req", 32'(mem_req), 32'd0);
        chk("t5_rst_we", 32'(mem_we), 32'd0);
        chk("t5_rst_addr", 32'(mem_addr), 32'd0);
        chk("t5_rst_load", 32'(load_pixel), 32'd0);
        chk("t5_rst_pix", 32'(pix_index), 32'd0);
        chk("t5_rst_shift", 32'(shift_lr), 32'd0);
        chk("t5_rst_calc", 32'(calc_start), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(image_done), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        expq.delete();
        exp_win(16'h0500, 3, 0, 0); expq.push_back(ev_wr(16'h0600));
        run_image("t5b", 10'd3, 10'd3, 16'h0500, 16'h0600, 0, -1, 1'b0);
        compare_events("t5b");

        // Address wrap from 0xFFFE, with a start pulse mid-image that must be ignored
        expq.delete();
        exp_win(16'hFFFE, 3, 0, 0); expq.push_back(ev_wr(16'h0010));
        run_image("t6", 10'd3, 10'd3, 16'hFFFE, 16'h0010, 0, 4, 1'b0);
        compare_events("t6");
        @(negedge clk);
        chk("t6_idle_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
